mem_arbiter: RTL and testbench

Arbitrates the single unified main memory between the I-cache and D-cache miss controllers. Each controller holds a level request (read, or D-side write-back) until its ready pulse, exactly as if it owned the memory. The arbiter grants one requester at a time, round-robin on contention, and keeps a D write-back plus refill pair atomic. It sits between the two cache control FSMs and the memory model.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 42 ++++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the I/D main-memory arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
//   arb_state_e             : arbiter state (IDLE, I_RD, D_RD, D_WR)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_RD = 2'd2,
        D_WR = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational grant decision used while the arbiter is idle.
//   i_re       : I-cache read request
//   d_re, d_we : D-cache read / write-back requests
//   last_d     : 1 when the D side was the last one served
//   lock       : 1 in the idle cycle right after a D write-back completed
//   next_state : state to enter next (IDLE when nobody asks)
// ---------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_re,
    input  logic       d_re,
    input  logic       d_we,
    input  logic       last_d,
    input  logic       lock,
    output arb_state_e next_state
);

    logic       dReq;
    arb_state_e dGrant;

    // The lock keeps a write-back and its refill together; otherwise a
    // lone requester wins outright and a tie goes to whoever was not
    // served last. A write-back request overrides a simultaneous read.
    always_comb begin
        dReq       = d_re | d_we;
        dGrant     = d_we ? D_WR : D_RD;
        next_state = IDLE;
        if (dReq && lock) begin
            next_state = dGrant;
        end else if (dReq && i_re) begin
            next_state = last_d ? I_RD : dGrant;
        end else if (dReq) begin
            next_state = dGrant;
        end else if (i_re) begin
            next_state = I_RD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one main memory between the I-cache and D-cache miss controllers.
// Each side holds a level request until its one-cycle rdy pulse; the
// arbiter serves one side at a time, round-robin on contention, and keeps a
// D write-back followed by its refill read back to back.
//   clk, rst                    : clock, synchronous active-high reset
//   i_re, i_addr                : I-side read request and address
//   i_rdy, i_rdata              : I-side completion pulse and read data
//   d_re, d_we, d_addr, d_wdata : D-side read / write-back request
//   d_rdy, d_rdata              : D-side completion pulse and read data
//   mem_re, mem_we, mem_addr,
//   mem_wdata                   : memory command (combinational from state)
//   mem_rdata, mem_drdy         : memory read data and completion pulse
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rdy,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rdy,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_drdy
);

    arb_state_e state_q, state_d;
    arb_state_e pickState;
    logic       lastD_q, lastD_d;
    logic       lock_q, lock_d;

    mem_arb_pick u_pick (
        .i_re       (i_re),
        .d_re       (d_re),
        .d_we       (d_we),
        .last_d     (lastD_q),
        .lock       (lock_q),
        .next_state (pickState)
    );

    // Read data goes straight through; it only matters alongside a rdy.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // Memory command follows the granted requester's live inputs. A
    // completion pulse returns to IDLE and records who was served; a write-
    // back completion arms the lock for exactly the following idle cycle.
    // If the owner withdraws before the memory answers, the access is
    // dropped silently. rdy is held off while reset is being sampled so an
    // abandoned access never reports completion.
    always_comb begin
        state_d   = state_q;
        lastD_d   = lastD_q;
        lock_d    = lock_q;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_rdy     = 1'b0;
        d_rdy     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = pickState;
                lock_d  = 1'b0;
            end
            I_RD: begin
                mem_re   = 1'b1;
                mem_addr = i_addr;
                if (mem_drdy) begin
                    i_rdy   = ~rst;
                    lastD_d = 1'b0;
                    state_d = IDLE;
                end else if (!i_re) begin
                    state_d = IDLE;
                end
            end
            D_RD: begin
                mem_re   = 1'b1;
                mem_addr = d_addr;
                if (mem_drdy) begin
                    d_rdy   = ~rst;
                    lastD_d = 1'b1;
                    state_d = IDLE;
                end else if (!(d_re || d_we)) begin
                    state_d = IDLE;
                end
            end
            D_WR: begin
                mem_we    = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                if (mem_drdy) begin
                    d_rdy   = ~rst;
                    lastD_d = 1'b1;
                    lock_d  = 1'b1;
                    state_d = IDLE;
                end else if (!(d_re || d_we)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, round-robin history and lock registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lastD_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lastD_q <= lastD_d;
            lock_q  <= lock_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Drives both cache sides from request queues, answers from a memory with
// configurable latency, and compares every cycle against a reference of the
// arbitration rules. Directed scenarios check service order and latency.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          iRe;
    logic [AW-1:0] iAddr;
    logic          iRdy;
    logic [DW-1:0] iRdata;
    logic          dRe;
    logic          dWe;
    logic [AW-1:0] dAddr;
    logic [DW-1:0] dWdata;
    logic          dRdy;
    logic [DW-1:0] dRdata;
    logic          memRe;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata;
    logic [DW-1:0] memRdata;
    logic          memDrdy;

    typedef struct {
        logic          re;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } dOp_t;

    logic [AW-1:0] iQ[$];
    dOp_t          dQ[$];

    // Reference: who owns the memory (0 none, 1 I, 2 D), whether the D
    // access is a write, who was served last, and the write-back lock.
    int    owner;
    bit    mWrite;
    bit    mLastD;
    bit    mLock;
    int    memCnt;
    int    memLat;
    int    latCfg;
    bit    spurious;
    int    cyc;
    int    iRdyCyc;
    int    startCyc;
    string order;
    int    numChecks;
    int    numFails;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_re      (iRe),
        .i_addr    (iAddr),
        .i_rdy     (iRdy),
        .i_rdata   (iRdata),
        .d_re      (dRe),
        .d_we      (dWe),
        .d_addr    (dAddr),
        .d_wdata   (dWdata),
        .d_rdy     (dRdy),
        .d_rdata   (dRdata),
        .mem_re    (memRe),
        .mem_we    (memWe),
        .mem_addr  (memAddr),
        .mem_wdata (memWdata),
        .mem_rdata (memRdata),
        .mem_drdy  (memDrdy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushD(input logic re, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        dOp_t op;
        op.re    = re;
        op.we    = we;
        op.addr  = addr;
        op.wdata = wdata;
        dQ.push_back(op);
    endtask

    // Each side requests whatever is at the head of its queue.
    task automatic applyStimulus();
        iRe   = 1'b0;
        iAddr = '0;
        if (iQ.size() > 0) begin
            iRe   = 1'b1;
            iAddr = iQ[0];
        end
        dRe    = 1'b0;
        dWe    = 1'b0;
        dAddr  = '0;
        dWdata = '0;
        if (dQ.size() > 0) begin
            dRe    = dQ[0].re;
            dWe    = dQ[0].we;
            dAddr  = dQ[0].addr;
            dWdata = dQ[0].wdata;
        end
    endtask

    // One clock: memory response, output checks, queue pops, model step.
    task automatic evalCycle();
        bit expIRdy;
        bit expDRdy;
        bit iReq;
        bit dReq;
        int pick;
        memRdata = DW'($urandom);
        memDrdy  = (owner != 0) ? (memCnt == memLat - 1) : spurious;
        #2;
        expIRdy = memDrdy && (owner == 1) && !rst;
        expDRdy = memDrdy && (owner == 2) && !rst;
        checkOutput("memRe", 32'(memRe), 32'((owner == 1) || (owner == 2 && !mWrite)));
        checkOutput("memWe", 32'(memWe), 32'(owner == 2 && mWrite));
        if (owner == 1) checkOutput("memAddrI", 32'(memAddr), 32'(iAddr));
        if (owner == 2) checkOutput("memAddrD", 32'(memAddr), 32'(dAddr));
        if (owner == 2 && mWrite) checkOutput("memWdata", 32'(memWdata), 32'(dWdata));
        checkOutput("iRdy", 32'(iRdy), 32'(expIRdy));
        checkOutput("dRdy", 32'(dRdy), 32'(expDRdy));
        if (expIRdy) checkOutput("iRdata", 32'(iRdata), 32'(memRdata));
        if (expDRdy) checkOutput("dRdata", 32'(dRdata), 32'(memRdata));
        if (iRdy === 1'b1) begin
            order   = {order, "I"};
            iRdyCyc = cyc;
        end
        if (dRdy === 1'b1) order = {order, "D"};
        if (expIRdy && iQ.size() > 0) void'(iQ.pop_front());
        if (expDRdy && dQ.size() > 0) void'(dQ.pop_front());

        iReq = iRe;
        dReq = dRe || dWe;
        if (rst) begin
            owner  = 0;
            mLastD = 1'b0;
            mLock  = 1'b0;
        end else if (owner == 0) begin
            // D wins when it asks and is locked in, unopposed, or due a turn.
            pick = 0;
            if (dReq && (mLock || !iReq || !mLastD)) pick = 2;
            else if (iReq) pick = 1;
            mLock = 1'b0;
            if (pick != 0) begin
                owner  = pick;
                mWrite = dWe;
                memCnt = 0;
                memLat = (latCfg > 0) ? latCfg : int'($urandom_range(1, 4));
            end
        end else if (memDrdy) begin
            mLastD = (owner == 2);
            mLock  = (owner == 2) && mWrite;
            owner  = 0;
        end else if ((owner == 1 && !iReq) || (owner == 2 && !dReq)) begin
            owner = 0;
        end else begin
            memCnt++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic runFor(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus();
            evalCycle();
        end
    endtask

    task automatic runUntilDrained(input int budget);
        int pending;
        for (int k = 0; k < budget; k++) begin
            applyStimulus();
            evalCycle();
            if (iQ.size() == 0 && dQ.size() == 0 && owner == 0) break;
        end
        pending = iQ.size() + dQ.size() + ((owner != 0) ? 1 : 0);
        checkOutput("drainTimeout", 32'(pending), 32'd0);
    endtask

    task automatic doReset();
        iQ.delete();
        dQ.delete();
        rst = 1'b1;
        applyStimulus();
        evalCycle();
        rst   = 1'b0;
        order = "";
    endtask

    initial begin
        numChecks = 0;
        numFails  = 0;
        owner     = 0;
        mWrite    = 1'b0;
        mLastD    = 1'b0;
        mLock     = 1'b0;
        memCnt    = 0;
        memLat    = 1;
        latCfg    = 0;
        spurious  = 1'b0;
        cyc       = 0;
        iRdyCyc   = -1;
        startCyc  = 0;
        order     = "";
        rst       = 1'b1;
        memDrdy   = 1'b0;
        memRdata  = '0;
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then an idle cycle.
        doReset();
        runFor(2);

        // I alone, memory latency 4.
        latCfg   = 4;
        order    = "";
        iQ.push_back(16'h0040);
        startCyc = cyc;
        iRdyCyc  = -1;
        runUntilDrained(20);
        checkOutput("iAloneLatency", 32'(iRdyCyc - startCyc), 32'd4);
        runFor(2);

        // Tie straight after reset: D first, then I.
        doReset();
        latCfg = 2;
        iQ.push_back(16'h0100);
        pushD(1'b1, 1'b0, 16'h0200, 16'h0000);
        runUntilDrained(40);
        checkOutput("tieOrder", 32'(order == "DI"), 32'd1);

        // Sustained contention alternates.
        doReset();
        latCfg = 3;
        for (int k = 0; k < 3; k++) begin
            iQ.push_back(16'h0400 + 16'(k));
            pushD(1'b1, 1'b0, 16'h0800 + 16'(k), 16'h0000);
        end
        runUntilDrained(80);
        checkOutput("contentionOrder", 32'(order == "DIDIDI"), 32'd1);

        // Dirty miss: write-back then refill stay together ahead of I.
        doReset();
        latCfg = 3;
        iQ.push_back(16'h0040);
        pushD(1'b0, 1'b1, 16'h1230, 16'hBEEF);
        pushD(1'b1, 1'b0, 16'h1230, 16'h0000);
        runUntilDrained(60);
        checkOutput("dirtyMissOrder", 32'(order == "DDI"), 32'd1);

        // Illegal read+write is served as a write.
        doReset();
        latCfg = 2;
        pushD(1'b1, 1'b1, 16'h0300, 16'h1111);
        runUntilDrained(20);
        checkOutput("illegalOrder", 32'(order == "D"), 32'd1);

        // Abort an I read; nothing completes and round-robin is untouched.
        doReset();
        latCfg = 10;
        iQ.push_back(16'h0100);
        runFor(3);
        iQ.delete();
        runFor(2);
        checkOutput("abortNoRdy", 32'(order.len()), 32'd0);
        latCfg = 2;
        iQ.push_back(16'h0110);
        pushD(1'b1, 1'b0, 16'h0210, 16'h0000);
        runUntilDrained(40);
        checkOutput("abortTieOrder", 32'(order == "DI"), 32'd1);

        // Reset in the middle of a write-back, then a stale drdy.
        doReset();
        latCfg = 10;
        pushD(1'b0, 1'b1, 16'h0500, 16'h2222);
        runFor(3);
        doReset();
        spurious = 1'b1;
        runFor(1);
        spurious = 1'b0;
        runFor(1);
        checkOutput("resetNoRdy", 32'(order.len()), 32'd0);

        // Randomized traffic.
        latCfg = 0;
        doReset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset();
            end else begin
                if (iQ.size() < 3 && $urandom_range(0, 3) == 0)
                    iQ.push_back(AW'($urandom));
                if (dQ.size() < 3 && $urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3, 4: pushD(1'b1, 1'b0, AW'($urandom), DW'($urandom));
                        9:             pushD(1'b1, 1'b1, AW'($urandom), DW'($urandom));
                        default:       pushD(1'b0, 1'b1, AW'($urandom), DW'($urandom));
                    endcase
                end
                if (iQ.size() > 0 && $urandom_range(0, 39) == 0) void'(iQ.pop_front());
                if (dQ.size() > 0 && $urandom_range(0, 39) == 0) void'(dQ.pop_front());
                spurious = ($urandom_range(0, 7) == 0);
                applyStimulus();
                evalCycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
